mainfsm: RTL
============

MAINFSM -- requirements
Module: mainfsm

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low (0 = reset).
REQ-003 SHALL have ports: Op  in  2  instruction class; Funct  in  6  instruction funct bits.
REQ-004 SHALL have ports: Reg2W  in  1  second writeback (long multiply); PreIndex  in  1  base writeback; NoWrite  in  1  suppress ALU writeback.
REQ-005 SHALL have ports: MemReady  in  1  memory completes access this cycle.
REQ-006 SHALL have ports: MemReq  out  1  memory access request; MemW  out  1  write strobe; AdrSrc  out  1  address select (0 = PC, 1 = ALU result).
REQ-007 SHALL have ports: IRWrite  out  1; NextPC  out  1; RegW  out  1; Branch  out  1; ALUOp  out  1; WrSel  out  1  (0 = Rd, 1 = second destination).
REQ-008 SHALL have ports: ALUSrcA  out  2  (00 reg, 01 PC, 10 PC+8); ALUSrcB  out  2  (00 reg, 01 imm, 10 const 4); ResultSrc  out  2  (00 ALUOut, 01 read data, 10 ALU direct, 11 product high); State  out  4.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, IDXWB, EXECUTER, EXECUTEI, ALUWB, ALUWB2, BRANCH; all unlisted outputs are 0.
REQ-010 FETCH: MemReq=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=MemReady; holds until MemReady=1, then DECODE.
REQ-011 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; next: Op=01 -> MEMADR; Op=10 -> BRANCH; Op=00/11 with Funct[5]=1 -> EXECUTEI, else EXECUTER.
REQ-012 MEMADR: ALUSrcB=01; next MEMREAD if Funct[0]=1 else MEMWRITE.
REQ-013 MEMREAD: MemReq=1, AdrSrc=1; holds until MemReady, then MEMWB.
REQ-014 MEMWRITE: MemReq=1, MemW=1, AdrSrc=1; holds until MemReady, then IDXWB if PreIndex else FETCH.
REQ-015 MEMWB: ResultSrc=01, RegW=1; next IDXWB if PreIndex else FETCH.
REQ-016 IDXWB: ALUSrcB=01, ResultSrc=10, RegW=1, WrSel=1; next FETCH.
REQ-017 EXECUTER: ALUOp=1, ALUSrcB=00; EXECUTEI: ALUOp=1, ALUSrcB=01; both next ALUWB.
REQ-018 ALUWB: ResultSrc=00, RegW=~NoWrite; next ALUWB2 if Reg2W (and feature enabled) else FETCH.
REQ-019 ALUWB2: ResultSrc=11, RegW=1, WrSel=1; next FETCH.
REQ-020 BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1; next FETCH.
REQ-021 Op, Funct, Reg2W, PreIndex, NoWrite SHALL be sampled only in the state whose transition uses them; MemReady SHALL be ignored outside FETCH/MEMREAD/MEMWRITE.
REQ-022 MemW SHALL remain asserted and stable across every MEMWRITE wait cycle; exactly one register write per writeback state.
REQ-023 Minimum latencies: ALU 4 cycles, branch 3, load 5, store 4, +1 for IDXWB/ALUWB2, +1 per MemReady=0 cycle.

Reset
REQ-024 reset=0 SHALL force State=FETCH immediately, asynchronously, including mid-wait; all outputs take FETCH values with IRWrite=NextPC=0 while reset=0.
REQ-025 First FETCH after reset release SHALL issue MemReq=1 in the first clock cycle.

Configuration
REQ-026 Macro MAINFSM_LONG_MUL_EN defined: ALUWB2 exists, Reg2W honoured; undefined: Reg2W ignored, ALUWB always -> FETCH, ResultSrc=11 never driven.

Structure
REQ-027 State encoding (4-bit constants) and ALUSrcA/ALUSrcB/ResultSrc select codes SHALL live in a shared package used by datapath muxes.
REQ-028 Sub-module mainfsm_outdec (state -> output decode, combinational) SHALL be the only child.

Verification
REQ-029 Reset mid-MEMREAD, MemReady=0: reset=0 -> State=FETCH same cycle, MemReq=1, IRWrite=0.
REQ-030 ADD reg (Op=00, Funct=001000), MemReady=1: FETCH, DECODE, EXECUTER, ALUWB, FETCH; RegW=1 only in ALUWB.
REQ-031 LDR pre-index (Op=01, Funct[0]=1, PreIndex=1), 2 wait cycles: FETCH, DECODE, MEMADR, MEMREAD x3, MEMWB, IDXWB, FETCH; WrSel=1 only in IDXWB.
REQ-032 CMP (NoWrite=1): ALUWB RegW=0.
REQ-033 Long multiply (Op=11, Reg2W=1): with macro ALUWB -> ALUWB2 (ResultSrc=11, WrSel=1); without macro ALUWB -> FETCH.
REQ-034 Branch (Op=10): 3 cycles, Branch=1 only in BRANCH, ALUSrcA=10.

Source files
------------

// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, datapath mux selects, control bundle.
package mainfsm_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_IDXWB    = 4'd6;
  localparam logic [3:0] S_EXECUTER = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_ALUWB2   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;
  localparam logic [1:0] SRCA_PC8 = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_PRODHI = 2'b11;

  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_w;
    logic       adr_src;
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       branch;
    logic       alu_op;
    logic       wr_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/mainfsm_if.sv
// Memory handshake between the control FSM (master) and the memory port (slave).
interface mainfsm_if;
  logic MemReady;
  logic MemReq;
  logic MemW;
  logic AdrSrc;

  modport master (input MemReady, output MemReq, output MemW, output AdrSrc);
  modport slave  (output MemReady, input MemReq, input MemW, input AdrSrc);
endinterface

// File: rtl/mainfsm_outdec.sv
// Combinational state -> control decode; ALUWB2 decode exists only with MAINFSM_LONG_MUL_EN.
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  logic [3:0] state,
  input  logic       rst_n,
  input  logic       mem_ready,
  input  logic       no_write,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        // Instruction latch and PC bump are held off while reset is asserted.
        ctrl.ir_write   = mem_ready & rst_n;
        ctrl.next_pc    = mem_ready & rst_n;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      S_MEMADR: ctrl.alu_src_b = SRCB_IMM;
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_w   = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_w      = 1'b1;
      end
      S_IDXWB: begin
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.reg_w      = 1'b1;
        ctrl.wr_sel     = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_op    = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
      end
      S_EXECUTEI: begin
        ctrl.alu_op    = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = ~no_write;
      end
`ifdef MAINFSM_LONG_MUL_EN
      S_ALUWB2: begin
        ctrl.result_src = RES_PRODHI;
        ctrl.reg_w      = 1'b1;
        ctrl.wr_sel     = 1'b1;
      end
`endif
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_PC8;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main control FSM (Moore). Define MAINFSM_LONG_MUL_EN to enable the ALUWB2
// second-writeback state for long multiplies.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       Reg2W,
  input  logic       PreIndex,
  input  logic       NoWrite,
  mainfsm_if.master  mem,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       WrSel,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] State
);

  logic [3:0] state_d, state_q;
  ctrl_t      ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:    state_d = S_MEMADR;
          OP_BRANCH: state_d = S_BRANCH;
          default:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem.MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (mem.MemReady) state_d = PreIndex ? S_IDXWB : S_FETCH;
      S_MEMWB:    state_d = PreIndex ? S_IDXWB : S_FETCH;
      S_IDXWB:    state_d = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI: state_d = S_ALUWB;
`ifdef MAINFSM_LONG_MUL_EN
      S_ALUWB:    state_d = Reg2W ? S_ALUWB2 : S_FETCH;
      S_ALUWB2:   state_d = S_FETCH;
`else
      S_ALUWB:    state_d = S_FETCH;
`endif
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifndef MAINFSM_LONG_MUL_EN
  logic unused_reg2w;
  assign unused_reg2w = Reg2W;
`endif
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  mainfsm_outdec u_outdec (
    .state     (state_q),
    .rst_n     (reset),
    .mem_ready (mem.MemReady),
    .no_write  (NoWrite),
    .ctrl      (ctrl)
  );

  assign mem.MemReq = ctrl.mem_req;
  assign mem.MemW   = ctrl.mem_w;
  assign mem.AdrSrc = ctrl.adr_src;
  assign IRWrite    = ctrl.ir_write;
  assign NextPC     = ctrl.next_pc;
  assign RegW       = ctrl.reg_w;
  assign Branch     = ctrl.branch;
  assign ALUOp      = ctrl.alu_op;
  assign WrSel      = ctrl.wr_sel;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ResultSrc  = ctrl.result_src;
  assign State      = state_q;

endmodule
